pump_relay_guard: RTL
=====================

Name: pump_relay_guard

Overview:
- Sits directly downstream of the manual timed-volume relay controller and the auto-fill controller. Drives the physical pump relay.
- Selects the active relay request from `mode`.
- Protects the pump with two limits: a minimum off-time between runs and a maximum continuous on-time watchdog.
- Converts relay on-time into a dispensed-volume count in ml for the display path.

Parameters:
- MIN_OFF_CYC, 500000, relay-off cycles enforced after every run (0.5 s at 1 MHz).
- MAX_ON_CYC, 40000000, continuous on-cycles that trip the watchdog fault (40 s).
- CYC_PER_ML, 34091, relay-on clk cycles per dispensed ml (pump calibration).
- VOL_W, 20, width of the volume accumulator.

Ports:
- clk  in  1  system clock, 1 MHz.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 = manual, 01 = auto, 10/11 = no source selected.
- relay_manual  in  1  relay request from the manual volume controller.
- relay_auto  in  1  relay request from the auto-fill controller.
- estop  in  1  emergency stop switch, level, active-high.
- fault_clr  in  1  single-cycle pulse that acknowledges a watchdog fault.
- clr_vol  in  1  single-cycle pulse that zeroes the volume counters.
- relay_out  out  1  registered pump relay drive.
- vol_ml  out  VOL_W  accumulated dispensed volume in ml.
- fault  out  1  high while the watchdog fault is latched.
- busy  out  1  high in ON or COOLDOWN.

Behaviour:
- Reset (async, any state, mid-run included):
  - FSM goes to IDLE.
  - relay_out=0, fault=0, busy=0, vol_ml=0.
  - All internal counters are 0.
- Request select (combinational): req = relay_manual when mode=00; relay_auto when mode=01; otherwise 0.
- All outputs are registered.

FSM states: IDLE, ON, COOLDOWN, FAULT.
- IDLE:
  - relay_out=0.
  - Moves to ON when req=1 and estop=0. relay_out goes high on the same edge, i.e. one cycle after req is sampled.
  - on_cnt is cleared on entry to ON.
- ON:
  - relay_out=1; on_cnt increments every cycle.
  - Exit priority, highest first:
    1. estop=1 -> COOLDOWN.
    2. on_cnt == MAX_ON_CYC-1 -> FAULT.
    3. req=0 (this includes a mode change that deselects the source) -> COOLDOWN.
  - relay_out drops on the exit edge.
- COOLDOWN:
  - relay_out=0; off_cnt counts from 0.
  - Goes to IDLE after exactly MIN_OFF_CYC cycles.
  - Requests are ignored. A req still high on the return to IDLE restarts the pump on the next edge; this is a legal re-trigger.
- FAULT:
  - relay_out=0, fault=1.
  - fault_clr=1 with req=0 -> COOLDOWN, and fault clears on the same edge.
  - fault_clr while req=1 is ignored, so the pump cannot auto-restart.
- estop in IDLE, COOLDOWN or FAULT: no effect beyond blocking the IDLE->ON transition.

Volume accounting:
- Applies only in cycles where relay_out=1.
- ml_cnt increments each such cycle. At CYC_PER_ML-1 it wraps to 0 and vol_ml increments.
- vol_ml saturates at all-ones and never wraps.
- The fractional ml_cnt is retained across runs.
- clr_vol zeroes vol_ml and ml_cnt. When clr_vol coincides with an increment, clr_vol wins.

Optional Feature:
- Macro: SESSION_COUNT_EN.
- Defined:
  - Adds output port session_cnt (8 bits, reset 0).
  - Increments on every IDLE->ON transition and saturates at 255.
  - Cleared by clr_vol, which takes priority over the increment.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
(Sim parameters: MIN_OFF_CYC=10, MAX_ON_CYC=100, CYC_PER_ML=4.)
1. mode=00, relay_manual high for 40 cycles, then low -> relay_out high 40 cycles, starting one cycle after the request; vol_ml=10; busy low 10 cycles after relay_out falls.
2. mode=01, relay_auto held high for 150 cycles -> relay_out falls after 100 cycles, fault=1. fault_clr with req=1 -> fault stays 1. Drop req, then fault_clr -> fault=0, IDLE after 10 cycles.
3. Manual run, estop asserted on cycle 20 of ON -> relay_out=0 on the next edge, COOLDOWN; request ignored until 10 cycles elapse.
4. mode switched from 00 to 10 mid-run with relay_manual still high -> relay_out drops next edge; no restart while mode=10.
5. Two runs of 6 cycles each -> vol_ml=3 (fraction carried over). clr_vol coincident with a wrap -> vol_ml=0, ml_cnt=0.
6. rst pulsed mid-ON -> relay_out=0 asynchronously, vol_ml=0. With SESSION_COUNT_EN defined, three runs -> session_cnt=3; rst -> 0.

Source files
------------

// File: rtl/pump_relay_guard.sv
// Pump relay guard: source select, min off-time, max on-time watchdog, ml accounting.
// Optional SESSION_COUNT_EN adds an 8-bit saturating count of pump starts.
module pump_relay_guard #(
  parameter int unsigned MIN_OFF_CYC = 500000,
  parameter int unsigned MAX_ON_CYC  = 40000000,
  parameter int unsigned CYC_PER_ML  = 34091,
  parameter int unsigned VOL_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             relay_manual,
  input  logic             relay_auto,
  input  logic             estop,
  input  logic             fault_clr,
  input  logic             clr_vol,
  output logic             relay_out,
  output logic [VOL_W-1:0] vol_ml,
  output logic             fault,
  output logic             busy
`ifdef SESSION_COUNT_EN
  ,
  output logic [7:0]       session_cnt
`endif
);

  localparam int unsigned ON_W  = $clog2(MAX_ON_CYC + 1);
  localparam int unsigned OFF_W = $clog2(MIN_OFF_CYC + 1);
  localparam int unsigned ML_W  = $clog2(CYC_PER_ML + 1);
  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(MAX_ON_CYC - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(MIN_OFF_CYC - 1);
  localparam logic [ML_W-1:0]  ML_LAST  = ML_W'(CYC_PER_ML - 1);

  typedef enum logic [1:0] {IDLE, ON, COOLDOWN, FAULT} state_t;

  state_t           state_q, state_d;
  logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
  logic [OFF_W-1:0] off_cnt_q, off_cnt_d;
  logic [ML_W-1:0]  ml_cnt_q, ml_cnt_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic             relay_q, relay_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic             req;

  always_comb begin
    case (mode)
      2'b00:   req = relay_manual;
      2'b01:   req = relay_auto;
      default: req = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    on_cnt_d  = on_cnt_q;
    off_cnt_d = off_cnt_q;
    case (state_q)
      IDLE: if (req && !estop) begin
        state_d  = ON;
        on_cnt_d = '0;
      end
      ON: begin
        on_cnt_d = on_cnt_q + 1'b1;
        if (estop) begin
          state_d   = COOLDOWN;
          off_cnt_d = '0;
        end else if (on_cnt_q == ON_LAST) begin
          state_d = FAULT;
        end else if (!req) begin
          state_d   = COOLDOWN;
          off_cnt_d = '0;
        end
      end
      COOLDOWN: begin
        if (off_cnt_q == OFF_LAST) state_d = IDLE;
        else                       off_cnt_d = off_cnt_q + 1'b1;
      end
      FAULT: if (fault_clr && !req) begin
        // A held request must be dropped first so the pump cannot self-restart.
        state_d   = COOLDOWN;
        off_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
    relay_d = (state_d == ON);
    fault_d = (state_d == FAULT);
    busy_d  = (state_d == ON) || (state_d == COOLDOWN);
  end

  // Volume follows the registered relay, so it tracks actual pump on-time.
  always_comb begin
    ml_cnt_d = ml_cnt_q;
    vol_d    = vol_q;
    if (clr_vol) begin
      ml_cnt_d = '0;
      vol_d    = '0;
    end else if (relay_q) begin
      if (ml_cnt_q == ML_LAST) begin
        ml_cnt_d = '0;
        if (vol_q != '1) vol_d = vol_q + 1'b1;
      end else begin
        ml_cnt_d = ml_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      on_cnt_q  <= '0;
      off_cnt_q <= '0;
      ml_cnt_q  <= '0;
      vol_q     <= '0;
      relay_q   <= 1'b0;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      off_cnt_q <= off_cnt_d;
      ml_cnt_q  <= ml_cnt_d;
      vol_q     <= vol_d;
      relay_q   <= relay_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
    end
  end

  assign relay_out = relay_q;
  assign vol_ml    = vol_q;
  assign fault     = fault_q;
  assign busy      = busy_q;

`ifdef SESSION_COUNT_EN
  logic [7:0] sess_q, sess_d;

  always_comb begin
    sess_d = sess_q;
    if (clr_vol)                                           sess_d = '0;
    else if (state_q == IDLE && state_d == ON && sess_q != 8'hFF) sess_d = sess_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sess_q <= '0;
    else     sess_q <= sess_d;
  end

  assign session_cnt = sess_q;
`endif

endmodule
